// File: rtl/r2sdf_stage_ctrl_if.sv
// ----------------------------------------------------------------------------
// r2sdf_stage_ctrl_if
// Groups the per-sample handshake and control outputs of one R2SDF stage
// sequencer.
//   master : the sample source / bench (drives iStart, iValid, iFlush)
//   slave  : the sequencer (drives the delay-buffer, butterfly and twiddle
//            controls plus oValid/oBusy)
// Signals:
//   iStart   frame start, qualified by iValid (marks sample 0)
//   iValid   input sample valid this cycle
//   iFlush   request to drain the buffered tail after the last frame
//   oBufEn   delay-buffer shift enable
//   oBfSel   0 = fill (buffer takes input), 1 = butterfly
//   oZeroIn  datapath substitutes a zero input (flush)
//   oTwEn    twiddle multiply active on the buffer-path output
//   oTwAddr  twiddle ROM index k (W_N^k), N_LOG2-1 bits
//   oValid   stage output valid this cycle
//   oBusy    sequencer is not idle
// ----------------------------------------------------------------------------
interface r2sdf_stage_ctrl_if #(
    parameter int N_LOG2 = 4
);
    logic              iStart;
    logic              iValid;
    logic              iFlush;
    logic              oBufEn;
    logic              oBfSel;
    logic              oZeroIn;
    logic              oTwEn;
    logic [N_LOG2-2:0] oTwAddr;
    logic              oValid;
    logic              oBusy;

    modport master (
        output iStart, iValid, iFlush,
        input  oBufEn, oBfSel, oZeroIn, oTwEn, oTwAddr, oValid, oBusy
    );

    modport slave (
        input  iStart, iValid, iFlush,
        output oBufEn, oBfSel, oZeroIn, oTwEn, oTwAddr, oValid, oBusy
    );
endinterface

// File: rtl/r2sdf_stage_ctrl.sv
// ----------------------------------------------------------------------------
// r2sdf_stage_ctrl
// Sequencer for one radix-2 single-delay-feedback FFT stage. Produces the
// delay-buffer shift enable, butterfly/bypass select, twiddle ROM address and
// output-valid for the sample presented at the stage input this cycle.
// Parameters:
//   N_LOG2  log2 of FFT size N (2..12)
//   STAGE   stage index 0..N_LOG2-1; delay D = 2**(N_LOG2-1-STAGE)
// Ports:
//   iClk    clock, rising edge
//   iRst_n  asynchronous reset, active low
//   bus     slave side of r2sdf_stage_ctrl_if (handshake in, controls out)
// ----------------------------------------------------------------------------
module r2sdf_stage_ctrl #(
    parameter int N_LOG2 = 4,
    parameter int STAGE  = 1
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    r2sdf_stage_ctrl_if.slave     bus
);

    localparam int AW     = N_LOG2 - 1;          // twiddle address width
    localparam int PH_BIT = N_LOG2 - 1 - STAGE;  // cnt bit that toggles every D samples
    localparam int D      = 1 << PH_BIT;
    localparam logic [AW-1:0] LOW_MASK = AW'(D - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t            state_q,      state_d;
    logic [N_LOG2-1:0] cnt_q,        cnt_d;
    logic              primed_q,     primed_d;
    logic              flush_pend_q, flush_pend_d;
    logic [AW-1:0]     fcnt_q,       fcnt_d;

    logic              start_hit;
    logic              sample_active;
    logic [N_LOG2-1:0] eff_cnt;
    logic              phase;
    logic              eff_primed;
    logic [AW-1:0]     low;
    logic [AW-1:0]     tw_run;
    logic [AW-1:0]     tw_flush;

    // A qualified start forces the current sample to index 0 and drops the
    // old frame's priming, so it needs no extra cycle to take effect.
    assign start_hit  = bus.iStart & bus.iValid;
    assign eff_cnt    = start_hit ? '0 : cnt_q;
    assign phase      = eff_cnt[PH_BIT];
    assign eff_primed = primed_q & ~start_hit;
    assign low        = eff_cnt[AW-1:0] & LOW_MASK;
    // Shifting within AW bits gives the required truncation for free.
    assign tw_run     = low << STAGE;
    assign tw_flush   = fcnt_q << STAGE;

    // The start sample itself is consumed in IDLE, so it is handled exactly
    // like a RUN sample at index 0.
    assign sample_active = ((state_q == IDLE) && start_hit) ||
                           ((state_q == RUN)  && bus.iValid);

    // NOTE: every signal written here gets a default first, so no path
    // through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        primed_d     = primed_q;
        flush_pend_d = flush_pend_q;
        fcnt_d       = fcnt_q;

        bus.oBufEn   = 1'b0;
        bus.oBfSel   = 1'b0;
        bus.oZeroIn  = 1'b0;
        bus.oTwEn    = 1'b0;
        bus.oTwAddr  = '0;
        bus.oValid   = 1'b0;
        bus.oBusy    = (state_q != IDLE);

        if (sample_active) begin
            bus.oBufEn  = 1'b1;
            bus.oBfSel  = phase;
            bus.oValid  = phase | eff_primed;
            bus.oTwEn   = ~phase & eff_primed;
            bus.oTwAddr = tw_run;
            cnt_d       = eff_cnt + N_LOG2'(1);
            // Once the buffer has been full for one half-period, every later
            // sample pushes a valid buffer-path result out.
            primed_d    = eff_primed | phase;
            state_d     = RUN;
        end

        case (state_q)
            RUN: begin
                if (bus.iFlush) begin
                    flush_pend_d = 1'b1;
                end
                // Drain only on a frame boundary with no sample arriving; a
                // valid sample at cnt==0 keeps the stream going.
                if (!bus.iValid && flush_pend_q && (cnt_q == '0)) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end
            end
            FLUSH: begin
                bus.oBufEn  = 1'b1;
                bus.oZeroIn = 1'b1;
                bus.oValid  = 1'b1;
                bus.oTwEn   = 1'b1;
                bus.oTwAddr = tw_flush;
                fcnt_d      = fcnt_q + AW'(1);
                if (fcnt_q == LOW_MASK) begin
                    state_d      = IDLE;
                    primed_d     = 1'b0;
                    flush_pend_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            primed_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            primed_q     <= primed_d;
            flush_pend_q <= flush_pend_d;
            fcnt_q       <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_r2sdf_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_r2sdf_stage_ctrl
// Bench for r2sdf_stage_ctrl with N_LOG2=4. Three sequencers (STAGE=1, 0, 3)
// share one stimulus stream. Directed tests target the STAGE=1 instance; the
// random phase checks all three against a sample-index reference model.
// Output bundle layout: {busy, bufen, bfsel, zero, twen, valid, twaddr[2:0]}.
// ----------------------------------------------------------------------------
module tb_r2sdf_stage_ctrl;

    localparam int N_LOG2 = 4;
    localparam int N      = 16;
    localparam int NDUT   = 3;

    logic iClk   = 1'b0;
    logic iRst_n = 1'b0;
    logic start  = 1'b0;
    logic valid  = 1'b0;
    logic flush  = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 iClk = ~iClk;

    r2sdf_stage_ctrl_if #(.N_LOG2(N_LOG2)) bus1 ();
    r2sdf_stage_ctrl_if #(.N_LOG2(N_LOG2)) bus0 ();
    r2sdf_stage_ctrl_if #(.N_LOG2(N_LOG2)) bus3 ();

    assign bus1.iStart = start; assign bus1.iValid = valid; assign bus1.iFlush = flush;
    assign bus0.iStart = start; assign bus0.iValid = valid; assign bus0.iFlush = flush;
    assign bus3.iStart = start; assign bus3.iValid = valid; assign bus3.iFlush = flush;

    r2sdf_stage_ctrl #(.N_LOG2(N_LOG2), .STAGE(1)) dut_s1 (.iClk(iClk), .iRst_n(iRst_n), .bus(bus1.slave));
    r2sdf_stage_ctrl #(.N_LOG2(N_LOG2), .STAGE(0)) dut_s0 (.iClk(iClk), .iRst_n(iRst_n), .bus(bus0.slave));
    r2sdf_stage_ctrl #(.N_LOG2(N_LOG2), .STAGE(3)) dut_s3 (.iClk(iClk), .iRst_n(iRst_n), .bus(bus3.slave));

    logic [8:0] act [NDUT];
    assign act[0] = {bus1.oBusy, bus1.oBufEn, bus1.oBfSel, bus1.oZeroIn, bus1.oTwEn, bus1.oValid, bus1.oTwAddr};
    assign act[1] = {bus0.oBusy, bus0.oBufEn, bus0.oBfSel, bus0.oZeroIn, bus0.oTwEn, bus0.oValid, bus0.oTwAddr};
    assign act[2] = {bus3.oBusy, bus3.oBufEn, bus3.oBfSel, bus3.oZeroIn, bus3.oTwEn, bus3.oValid, bus3.oTwAddr};

    int stg [NDUT] = '{1, 0, 3};

    task automatic check(input string name, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, a, e);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait for the
    // falling edge where the combinational outputs are stable.
    task automatic step(input logic s, input logic v, input logic f);
        @(posedge iClk);
        #1;
        start = s;
        valid = v;
        flush = f;
        @(negedge iClk);
    endtask

    // ---------------- reference model (sample-index view) ----------------
    // mode: 0 idle, 1 running, 2 draining. k counts valid samples since the
    // last start, so "buffer primed" is simply k > D.
    int m_mode  [NDUT];
    int m_k     [NDUT];
    bit m_pend  [NDUT];
    int m_fleft [NDUT];

    function automatic logic [8:0] emit_sample(input int k, input int d, input int st, input bit busy);
        int pos;
        bit ph;
        logic [8:0] e;
        pos = k % N;
        ph  = ((pos / d) % 2) == 1;
        e   = '0;
        e[8] = busy;
        e[7] = 1'b1;
        e[6] = ph;
        e[4] = !ph && (k > d);
        e[3] = ph || (k >= d);
        e[2:0] = 3'(((pos % d) << st) % 8);
        return e;
    endfunction

    task automatic model(input int i, input bit s, input bit v, input bit f, output logic [8:0] e);
        int d;
        int k;
        bit old_pend;
        d = 1 << (N_LOG2 - 1 - stg[i]);
        e = '0;
        case (m_mode[i])
            0: begin
                if (s && v) begin
                    e = emit_sample(0, d, stg[i], 1'b0);
                    m_mode[i] = 1;
                    m_k[i]    = 1;
                end
            end
            1: begin
                e[8] = 1'b1;
                old_pend = m_pend[i];
                if (f) m_pend[i] = 1'b1;
                if (v) begin
                    k = s ? 0 : m_k[i];
                    e = emit_sample(k, d, stg[i], 1'b1);
                    m_k[i] = k + 1;
                end else if (old_pend && (m_k[i] % N) == 0) begin
                    m_mode[i]  = 2;
                    m_fleft[i] = d;
                end
            end
            default: begin
                e = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'(((d - m_fleft[i]) << stg[i]) % 8)};
                m_fleft[i]--;
                if (m_fleft[i] == 0) begin
                    m_mode[i] = 0;
                    m_pend[i] = 1'b0;
                end
            end
        endcase
    endtask

    // ---------------- single-frame vector table (STAGE=1, D=4) ----------------
    typedef struct {
        logic       s;
        logic       v;
        logic       f;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [N];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        logic [15:0] bf_pat;
        logic [15:0] val_pat;
        logic [15:0] tw_pat;
        logic [8:0]  e;
        bit          seen;
        bit          s_r, v_r, f_r;
        bit          any_flush;
        bit          all_idle;

        bf_pat  = 16'b0000111100001111;
        val_pat = 16'b0000111111111111;
        tw_pat  = 16'b0000000011110000;
        for (int i = 0; i < N; i++) begin
            tbl[i].s   = (i == 0);
            tbl[i].v   = 1'b1;
            tbl[i].f   = 1'b0;
            tbl[i].exp = {(i != 0), 1'b1, bf_pat[15-i], 1'b0, tw_pat[15-i], val_pat[15-i], 3'((i % 4) * 2)};
        end

        // Reset: everything quiet, even with a valid sample presented.
        valid = 1'b1;
        #2;
        check("reset_outputs", act[0], 9'b0);
        @(negedge iClk);
        check("reset_outputs_s0", act[1], 9'b0);
        @(posedge iClk);
        #1;
        valid  = 1'b0;
        iRst_n = 1'b1;

        // Back-to-back single frame.
        for (int i = 0; i < N; i++) begin
            step(tbl[i].s, tbl[i].v, tbl[i].f);
            check($sformatf("frame[%0d]", i), act[0], tbl[i].exp);
        end

        // Same frame with a stall after every sample (restart in RUN).
        for (int i = 0; i < N; i++) begin
            step(i == 0, 1'b1, 1'b0);
            check($sformatf("stall_v[%0d]", i), act[0], tbl[i].exp | 9'h100);
            step(1'b0, 1'b0, 1'b0);
            check($sformatf("stall_x[%0d]", i), act[0], 9'h100);
        end

        // Flush: drain D=4 zero-input cycles, then idle.
        step(1'b0, 1'b0, 1'b1);
        check("flush_req", act[0], 9'h100);
        seen = 1'b0;
        for (int w = 0; w < 4 && !seen; w++) begin
            step(1'b0, 1'b0, 1'b0);
            seen = act[0][5];
        end
        check("flush_start", act[0][5], 1'b1);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step(1'b0, 1'b0, 1'b0);
            check($sformatf("flush[%0d]", j), act[0], {6'b110111, 3'(j * 2)});
        end
        step(1'b0, 1'b0, 1'b0);
        check("flush_idle", act[0], 9'b0);
        for (int w = 0; w < 8; w++) step(1'b0, 1'b0, 1'b0);
        check("flush_idle_s0", act[1], 9'b0);

        // Restart at sample 9: the frame pattern begins again from index 0.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].s, 1'b1, 1'b0);
            check($sformatf("pre_restart[%0d]", i), act[0], tbl[i].exp);
        end
        for (int k = 0; k < 8; k++) begin
            step(k == 0, 1'b1, 1'b0);
            check($sformatf("restart[%0d]", k), act[0], tbl[k].exp | 9'h100);
        end

        // Asynchronous reset mid-RUN with a valid sample presented.
        step(1'b0, 1'b1, 1'b0);
        #2;
        iRst_n = 1'b0;
        #1;
        check("midrun_reset_s1", act[0], 9'b0);
        check("midrun_reset_s0", act[1], 9'b0);
        @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("post_reset_nostart[%0d]", i), act[0], 9'b0);
        end

        // Random traffic on all three stages against the reference model.
        for (int i = 0; i < NDUT; i++) begin
            m_mode[i] = 0; m_k[i] = 0; m_pend[i] = 1'b0; m_fleft[i] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            any_flush = 1'b0;
            all_idle  = 1'b1;
            for (int i = 0; i < NDUT; i++) begin
                if (m_mode[i] == 2) any_flush = 1'b1;
                if (m_mode[i] != 0) all_idle = 1'b0;
            end
            v_r = ($urandom_range(0, 3) != 0);
            f_r = ($urandom_range(0, 29) == 0);
            s_r = !any_flush && (all_idle ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 59) == 0));
            step(s_r, v_r, f_r);
            for (int i = 0; i < NDUT; i++) begin
                model(i, s_r, v_r, f_r, e);
                check($sformatf("rand[%0d] stage%0d", c, stg[i]), act[i], e);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
